// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and write-request type for the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between WB stage, MDU, decode, the arbiter and the regfile write port.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic          pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          iss_valid;
    logic [AW-1:0] iss_dst;
    logic          iss_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic          pipe_hold;
    logic          rf_we;
    logic [AW-1:0] rf_addrW;
    logic [DW-1:0] rf_dataW;

    modport master (
        output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
               iss_valid, iss_dst, rs_addr, rt_addr,
        input  mdu_ready, iss_ready, rs_busy, rt_busy, pipe_hold,
               rf_we, rf_addrW, rf_dataW
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
               iss_valid, iss_dst, rs_addr, rt_addr,
        output mdu_ready, iss_ready, rs_busy, rt_busy, pipe_hold,
               rf_we, rf_addrW, rf_dataW
    );
endinterface

// File: rtl/rf_result_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module rf_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  wb_req_t                    wdata,
    input  logic                       pop,
    output wb_req_t                    rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign rdata = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between WB and buffered MDU results, and
// tracks pending long-latency destinations for decode interlocks.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [SW-1:0] STARVE_C  = SW'(STARVE_LIM);

    wb_req_t              head, wr;
    logic                 empty, full;
    logic [$clog2(DEPTH):0] count;
    logic                 pipe_req, push, pop, set, clr;
    logic [31:0]          pending, pending_nxt;
    logic [OW-1:0]        outstanding;
    logic [SW-1:0]        starve;

    assign pipe_req = bus.pipe_we && (bus.pipe_addr != REG_ZERO);
    assign pop      = !pipe_req && !empty;

    // Zero-destination results are accepted but never enter the FIFO.
    assign bus.mdu_ready = !full;
    assign push = bus.mdu_valid && !full && (bus.mdu_addr != REG_ZERO);

    rf_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ('{we: 1'b1, addr: bus.mdu_addr, data: bus.mdu_data}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always_comb begin
        wr = '0;
        if (pipe_req)
            wr = '{we: 1'b1, addr: bus.pipe_addr, data: bus.pipe_data};
        else if (!empty)
            wr = head;
    end

    assign bus.rf_we    = wr.we;
    assign bus.rf_addrW = wr.addr;
    assign bus.rf_dataW = wr.data;

    assign bus.iss_ready = !((bus.iss_dst != REG_ZERO) && pending[bus.iss_dst])
                           && (outstanding < MAX_OUT_C);
    assign bus.rs_busy   = (bus.rs_addr != REG_ZERO) && pending[bus.rs_addr];
    assign bus.rt_busy   = (bus.rt_addr != REG_ZERO) && pending[bus.rt_addr];

    assign set = bus.iss_valid && bus.iss_ready && (bus.iss_dst != REG_ZERO);
    assign clr = pop && pending[head.addr];

    // Set and clear never hit the same register since iss_ready blocks pending dsts.
    always_comb begin
        pending_nxt = pending;
        if (clr) pending_nxt[head.addr] = 1'b0;
        if (set) pending_nxt[bus.iss_dst] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending <= pending_nxt;
            case ({set, clr})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve <= '0;
        else if (empty || pop)
            starve <= '0;
        else if (starve != STARVE_C)
            starve <= starve + 1'b1;
    end

    assign bus.pipe_hold = (starve == STARVE_C);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Random + directed stimulus against a queue-based reference of the write-port arbiter.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH      = 2;
    localparam int MAX_OUT    = 4;
    localparam int STARVE_LIM = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];
    bit   pend[32];
    int   outst, starve;
    int   nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        outst  = 0;
        starve = 0;
    endtask

    task automatic cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic iv, input logic [4:0] id,
                         input logic [4:0] rs, input logic [4:0] rt);
        logic preq, mrdy, irdy, pop;
        logic [4:0]  ea;
        logic [31:0] ed;
        @(negedge clk);
        bus.pipe_we = pw; bus.pipe_addr = pa; bus.pipe_data = pd;
        bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
        bus.iss_valid = iv; bus.iss_dst = id;
        bus.rs_addr = rs; bus.rt_addr = rt;
        #1;
        preq = pw && pa != 0;
        mrdy = q.size() < DEPTH;
        irdy = !(id != 0 && pend[id]) && outst < MAX_OUT;
        if (preq) begin ea = pa; ed = pd; end
        else if (q.size() > 0) begin ea = q[0].a; ed = q[0].d; end
        else begin ea = 0; ed = 0; end
        chk("mdu_ready", bus.mdu_ready, mrdy);
        chk("iss_ready", bus.iss_ready, irdy);
        chk("rs_busy",   bus.rs_busy, rs != 0 && pend[rs]);
        chk("rt_busy",   bus.rt_busy, rt != 0 && pend[rt]);
        chk("pipe_hold", bus.pipe_hold, starve == STARVE_LIM);
        chk("rf_we",     bus.rf_we, preq || q.size() > 0);
        chk("rf_addrW",  bus.rf_addrW, ea);
        chk("rf_dataW",  bus.rf_dataW, ed);
        @(posedge clk);
        pop = !preq && q.size() > 0;
        starve = (q.size() > 0 && !pop) ? ((starve < STARVE_LIM) ? starve + 1 : starve) : 0;
        if (pop) begin
            if (pend[q[0].a]) begin pend[q[0].a] = 1'b0; outst--; end
            void'(q.pop_front());
        end
        if (mv && mrdy && ma != 0) q.push_back('{ma, md});
        if (iv && irdy && id != 0) begin pend[id] = 1'b1; outst++; end
    endtask

    task automatic idle(input logic [4:0] rs);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, rs, 0);
    endtask

    task automatic do_reset(input logic [4:0] rs);
        @(negedge clk);
        bus.mdu_valid = 0; bus.iss_valid = 0; bus.iss_dst = 5'd5;
        bus.rs_addr = rs; bus.rt_addr = rs;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_mdu_ready", bus.mdu_ready, 1'b1);
        chk("rst_iss_ready", bus.iss_ready, 1'b1);
        chk("rst_rs_busy",   bus.rs_busy, 1'b0);
        chk("rst_rt_busy",   bus.rt_busy, 1'b0);
        chk("rst_pipe_hold", bus.pipe_hold, 1'b0);
        chk("rst_rf_we",     bus.rf_we, bus.pipe_we && bus.pipe_addr != 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        pw, mv, iv;
        logic [4:0]  pa, ma, id;
        rst_n = 1'b0;
        bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
        bus.mdu_valid = 0; bus.mdu_addr = 0; bus.mdu_data = 0;
        bus.iss_valid = 0; bus.iss_dst = 0; bus.rs_addr = 0; bus.rt_addr = 0;
        do_reset(0);

        // Reset mid-operation discards the buffered r5 result and its pending bit.
        cycle(1, 5'd1, 32'hA, 0, 0, 0, 1, 5'd5, 5'd5, 0);
        cycle(1, 5'd2, 32'hB, 1, 5'd5, 32'h1234, 0, 0, 5'd5, 0);
        cycle(1, 5'd3, 32'hC, 0, 0, 0, 0, 0, 5'd5, 0);
        do_reset(5'd5);
        idle(5'd5);
        chk("post_rst_no_r5", bus.rf_we, 1'b0);

        // Issue r8, deliver it on an idle pipe, busy drops the cycle after the write.
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 0);
        idle(5'd8);
        cycle(0, 0, 0, 1, 5'd8, 32'hDEADBEEF, 0, 0, 5'd8, 5'd8);
        idle(5'd8);
        idle(5'd8);

        // Collision: pipe wins, MDU result follows next cycle.
        cycle(1, 5'd3, 32'h11, 1, 5'd9, 32'h22, 0, 0, 0, 0);
        idle(0);
        idle(0);

        // Backpressure and starvation hold, then drain.
        cycle(1, 5'd1, 32'h1, 1, 5'd10, 32'h100, 0, 0, 0, 0);
        cycle(1, 5'd1, 32'h2, 1, 5'd11, 32'h101, 0, 0, 0, 0);
        cycle(1, 5'd1, 32'h3, 1, 5'd12, 32'h102, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 5'd2, 32'h4 + i, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_set", bus.pipe_hold, 1'b1);
        for (int i = 0; i < 3; i++) idle(0);

        // Outstanding limit, reissue of pending dst, zero dst.
        for (int i = 1; i <= 5; i++) cycle(0, 0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd2, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, 5'(i), 32'hF0 + i, 0, 0, 5'(i), 0);
        for (int i = 0; i < 3; i++) idle(5'd4);

        // Zero-register writes from both sources.
        cycle(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 0, 0, 0, 0);
        idle(0);

        for (int n = 0; n < 3000; n++) begin
            pa = 5'($urandom_range(0, 7));
            pw = ($urandom_range(0, 99) < 45) && !pend[pa];
            ma = 5'($urandom_range(0, 7));
            mv = $urandom_range(0, 99) < 40;
            id = 5'($urandom_range(0, 7));
            iv = $urandom_range(0, 99) < 35;
            cycle(pw, pa, $urandom, mv, ma, $urandom, iv, id,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (n == 1500) do_reset(5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
